aes_spi_ctrl: RTL and testbench
===============================

AES_SPI_CTRL -- requirements
Module: aes_spi_ctrl

Interface
REQ-001 SHALL have parameter NK, default 4, meaning key length in 32-bit words (4, 6 or 8).
REQ-002 SHALL have parameter NR, default 10, meaning round count forwarded to the cipher core (10, 12 or 14).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port cs_n  input  1  SPI chip select, active-low frame enable.
REQ-006 SHALL have port simo  input  1  serial data in, sampled on posedge clk while cs_n=0.
REQ-007 SHALL have port mode  input  1  0=encrypt, 1=decrypt; sampled on the first frame bit.
REQ-008 SHALL have port somi  output  1  serial result out, registered.
REQ-009 SHALL have port msg_o  output  128  assembled message to the core.
REQ-010 SHALL have port key_o  output  NK*32  assembled key to the core.
REQ-011 SHALL have port mode_o  output  1  latched mode to the core.
REQ-012 SHALL have port start_o  output  1  one-cycle core start pulse.
REQ-013 SHALL have port core_done_i  input  1  core result-valid pulse.
REQ-014 SHALL have port core_data_i  input  128  core result.
REQ-015 SHALL have ports busy (output 1, high outside IDLE) and frame_err (output 1, one-cycle abort pulse).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD_MSG, LOAD_KEY, RUN, SHIFT_OUT.
REQ-017 IDLE -> LOAD_MSG SHALL occur on the first cycle cs_n=0; that cycle's simo is message bit 0 and mode is latched into mode_o.
REQ-018 LOAD_MSG SHALL shift simo LSB-first ({simo, msg[127:1]}); after exactly 128 bits -> LOAD_KEY.
REQ-019 LOAD_KEY SHALL shift LSB-first likewise; after exactly NK*32 bits -> RUN.
REQ-020 start_o SHALL be high for exactly one cycle, the cycle after the last key bit is sampled; msg_o/key_o SHALL be stable from then until the next frame begins.
REQ-021 RUN SHALL wait unbounded for core_done_i, capture core_data_i into a result register on that cycle, and go to SHIFT_OUT.
REQ-022 SHIFT_OUT SHALL drive somi = result[k] on output cycle k, k=0..127, LSB-first, then return to IDLE.
REQ-023 Bit counter SHALL be 9 bits wide, cleared on every state entry, and never wrap within a state.
REQ-024 cs_n=1 in LOAD_MSG, LOAD_KEY, RUN or SHIFT_OUT SHALL abort to IDLE next cycle with frame_err=1 for one cycle; a core_done_i arriving after the abort SHALL be ignored.
REQ-025 core_done_i outside RUN SHALL be ignored.
REQ-026 cs_n held low in IDLE after a completed frame SHALL start a new frame immediately (back-to-back frames).

Reset
REQ-027 rst_n=0 at a posedge SHALL force IDLE, counter=0, somi=0, start_o=0, busy=0, frame_err=0, mode_o=0, msg_o=0, key_o=0, result=0, overriding all other events including mid-frame.

Configuration
REQ-028 Macro AES_SPI_CTRL_DECRYPT_EN defined: mode=1 frames SHALL run normally with mode_o=1.
REQ-029 Macro undefined: a frame started with mode=1 SHALL be consumed through LOAD_KEY without asserting start_o, then return to IDLE with frame_err=1 for one cycle; mode_o SHALL be tied to 0.

Structure
REQ-030 Package aes_spi_pkg SHALL hold the FSM state enum, MSG_BITS=128 and the key-width function of NK.
REQ-031 One sub-module aes_shift_reg (parameterised-width LSB-first serial-in shift register with load enable) SHALL be instantiated for msg and key.

Verification
REQ-032 FIPS-197 frame: msg 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, mode=0, model core returns after 11 cycles -> start_o at cycle 256, somi stream = 69c4e0d86a7b0430d8cdb78070b4c55a LSB-first.
REQ-033 cs_n deasserted after 100 message bits -> IDLE next cycle, frame_err pulse, busy=0, no start_o.
REQ-034 core_done_i delayed 1000 cycles -> busy stays 1, somi=0 throughout, result correct afterwards.
REQ-035 rst_n=0 during SHIFT_OUT at bit 64 -> all outputs at reset values next cycle.
REQ-036 NK=8, NR=14 frame -> start_o after 384 bits; with macro undefined and mode=1 -> no start_o, frame_err after bit 384.

Source files
------------

// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: FSM encoding and frame geometry shared by the AES SPI controller files.
package aes_spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_MSG  = 3'd1,
    LOAD_KEY  = 3'd2,
    RUN       = 3'd3,
    SHIFT_OUT = 3'd4
  } state_t;

  localparam int MSG_BITS = 128;
  localparam int CNT_W    = 9;

  function automatic int key_bits(input int nk);
    return nk * 32;
  endfunction

endpackage

// File: rtl/aes_shift_reg.sv
// aes_shift_reg: W-bit serial-in shift register; each enabled cycle pushes din in at the MSB,
// so after W enabled cycles the first bit received sits at q[0] (LSB-first assembly).
module aes_shift_reg #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= {din, q[W-1:1]};
    end
  end

endmodule

// File: rtl/aes_spi_ctrl.sv
// aes_spi_ctrl: SPI front end for an AES core -- shifts message and key in LSB-first, pulses the
// core start, then streams the 128-bit result out on somi. Decrypt frames need AES_SPI_CTRL_DECRYPT_EN.
module aes_spi_ctrl
  import aes_spi_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              simo,
  input  logic              mode,
  output logic              somi,
  output logic [127:0]      msg_o,
  output logic [NK*32-1:0]  key_o,
  output logic              mode_o,
  output logic              start_o,
  input  logic              core_done_i,
  input  logic [127:0]      core_data_i,
  output logic              busy,
  output logic              frame_err,
  output state_t            dbg_state
);

  localparam int KEY_BITS = key_bits(NK);
  // Bit 0 of the message is taken in IDLE, so LOAD_MSG itself only sees 127 bits.
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BITS - 2);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BITS - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(MSG_BITS - 1);

`ifdef AES_SPI_CTRL_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  if (!((NK == 4 || NK == 6 || NK == 8) && (NR == 10 || NR == 12 || NR == 14))) begin : g_bad_cfg
    $error("aes_spi_ctrl: NK must be 4/6/8 and NR 10/12/14");
  end

  state_t state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [MSG_BITS-1:0] result;
  logic [6:0]          out_idx;
  logic mode_q, start_q, err_q, somi_q;
  logic abort, msg_last, key_last, reject, launch, capture, out_last, msg_en, key_en;

  assign abort    = (state != IDLE) && cs_n;
  assign msg_last = (state == LOAD_MSG)  && !cs_n && (cnt == MSG_LAST);
  assign key_last = (state == LOAD_KEY)  && !cs_n && (cnt == KEY_LAST);
  assign out_last = (state == SHIFT_OUT) && !cs_n && (cnt == OUT_LAST);
  assign capture  = (state == RUN)       && !cs_n && core_done_i;
  // A decrypt frame without decrypt support is drained completely, then refused.
  assign reject   = key_last && mode_q && !DEC_EN;
  assign launch   = key_last && !reject;
  assign msg_en   = !cs_n && ((state == IDLE) || (state == LOAD_MSG));
  assign key_en   = !cs_n && (state == LOAD_KEY);
  assign out_idx  = cnt[6:0] + 7'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!cs_n) state_next = LOAD_MSG;
      LOAD_MSG:  if (cs_n) state_next = IDLE;
                 else if (msg_last) state_next = LOAD_KEY;
      LOAD_KEY:  if (cs_n) state_next = IDLE;
                 else if (key_last) state_next = reject ? IDLE : RUN;
      RUN:       if (cs_n) state_next = IDLE;
                 else if (core_done_i) state_next = SHIFT_OUT;
      SHIFT_OUT: if (cs_n || out_last) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      mode_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      somi_q  <= 1'b0;
      result  <= '0;
    end else begin
      if (state_next != state) begin
        cnt <= '0;
      end else if ((state == LOAD_MSG) || (state == LOAD_KEY) || (state == SHIFT_OUT)) begin
        cnt <= cnt + 1'b1;
      end
      if ((state == IDLE) && !cs_n) begin
        mode_q <= mode;
      end
      start_q <= launch;
      err_q   <= abort || reject;
      if (capture) begin
        result <= core_data_i;
      end
      // somi is registered one bit ahead so that result[k] is on the pin in output cycle k.
      if (capture) begin
        somi_q <= core_data_i[0];
      end else if ((state == SHIFT_OUT) && !cs_n && !out_last) begin
        somi_q <= result[out_idx];
      end else begin
        somi_q <= 1'b0;
      end
    end
  end

  aes_shift_reg #(.W(MSG_BITS)) u_msg_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (msg_en),
    .din   (simo),
    .q     (msg_o)
  );

  aes_shift_reg #(.W(KEY_BITS)) u_key_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (key_en),
    .din   (simo),
    .q     (key_o)
  );

  assign start_o   = start_q;
  assign frame_err = err_q;
  assign somi      = somi_q;
`ifdef AES_SPI_CTRL_DECRYPT_EN
  assign mode_o = mode_q;
`else
  assign mode_o = 1'b0;
`endif

endmodule

// File: tb/tb_aes_spi_ctrl.sv
// tb_aes_spi_ctrl: drives SPI frames into NK=4 and NK=8 controllers, plays the AES core,
// and checks the somi result stream against a scoreboard queue.
`timescale 1ns/1ps
module tb_aes_spi_ctrl;
  import aes_spi_pkg::*;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, sel8, cs_n, simo, mode, core_done;
  logic [127:0] core_data;
  logic         cs_n_a, cs_n_b, done_a, done_b;
  logic         somi_a, somi_b, mode_a, mode_b, start_a, start_b, busy_a, busy_b, err_a, err_b;
  logic [127:0] msg_a, msg_b;
  logic [127:0] key_a;
  logic [255:0] key_b;
  state_t       dbg_a, dbg_b;
  logic         somi, mode_o, start_o, busy, frame_err;
  logic [127:0] msg_o;
  logic [255:0] key_sel;

  logic [127:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // The idle instance sees cs_n high and no done pulses while the other is exercised.
  assign cs_n_a    = sel8 ? 1'b1 : cs_n;
  assign cs_n_b    = sel8 ? cs_n : 1'b1;
  assign done_a    = sel8 ? 1'b0 : core_done;
  assign done_b    = sel8 ? core_done : 1'b0;
  assign somi      = sel8 ? somi_b  : somi_a;
  assign mode_o    = sel8 ? mode_b  : mode_a;
  assign start_o   = sel8 ? start_b : start_a;
  assign busy      = sel8 ? busy_b  : busy_a;
  assign frame_err = sel8 ? err_b   : err_a;
  assign msg_o     = sel8 ? msg_b   : msg_a;
  assign key_sel   = sel8 ? key_b   : {128'b0, key_a};

  aes_spi_ctrl #(.NK(4), .NR(10)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n_a), .simo(simo), .mode(mode), .somi(somi_a),
    .msg_o(msg_a), .key_o(key_a), .mode_o(mode_a), .start_o(start_a),
    .core_done_i(done_a), .core_data_i(core_data), .busy(busy_a), .frame_err(err_a),
    .dbg_state(dbg_a)
  );

  aes_spi_ctrl #(.NK(8), .NR(14)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n_b), .simo(simo), .mode(mode), .somi(somi_b),
    .msg_o(msg_b), .key_o(key_b), .mode_o(mode_b), .start_o(start_b),
    .core_done_i(done_b), .core_data_i(core_data), .busy(busy_b), .frame_err(err_b),
    .dbg_state(dbg_b)
  );

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drives message then key, one bit per cycle starting with cs_n falling; mode is inverted
  // after the first bit so only the first-bit sample may matter.
  task automatic load_frame(input logic [127:0] msg, input logic [255:0] key, input logic m,
                            input bit stray);
    int kb, early_start, not_busy;
    kb = sel8 ? 256 : 128;
    early_start = 0;
    not_busy = 0;
    for (int i = 0; i < 128 + kb; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (start_o !== 1'b0) early_start++;
        if (busy !== 1'b1) not_busy++;
      end
      cs_n      = 1'b0;
      simo      = (i < 128) ? msg[i] : key[i-128];
      mode      = (i == 0) ? m : ~m;
      core_done = stray && (i == 50);
      core_data = rand128();
    end
    n_checks++;
    if (early_start !== 0) $display("FAIL early_start: got %0d cycles with start_o, expected 0", early_start);
    else n_pass++;
    n_checks++;
    if (not_busy !== 0) $display("FAIL busy_load: got %0d idle cycles during load, expected 0", not_busy);
    else n_pass++;
  endtask

  task automatic check_start(input logic [127:0] msg, input logic [255:0] key, input logic m);
    logic [255:0] exp_key;
    logic exp_mode;
    exp_key = sel8 ? key : {128'b0, key[127:0]};
`ifdef AES_SPI_CTRL_DECRYPT_EN
    exp_mode = m;
`else
    exp_mode = 1'b0;
`endif
    @(negedge clk);
    n_checks++;
    if (start_o !== 1'b1) $display("FAIL start_pulse: got %b expected 1", start_o);
    else n_pass++;
    n_checks++;
    if (msg_o !== msg) $display("FAIL msg_o: got %h expected %h", msg_o, msg);
    else n_pass++;
    n_checks++;
    if (key_sel !== exp_key) $display("FAIL key_o: got %h expected %h", key_sel, exp_key);
    else n_pass++;
    n_checks++;
    if (mode_o !== exp_mode) $display("FAIL mode_o: got %b expected %b", mode_o, exp_mode);
    else n_pass++;
  endtask

  // Core model: waits lat cycles after start, then pulses done with res for one cycle.
  task automatic serve_core(input int lat, input logic [127:0] res);
    int bad;
    bad = 0;
    for (int t = 0; t < lat; t++) begin
      @(negedge clk);
      if (t == 0) begin
        n_checks++;
        if (start_o !== 1'b0) $display("FAIL start_width: got %b expected 0", start_o);
        else n_pass++;
      end
      if (busy !== 1'b1 || somi !== 1'b0 || frame_err !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL run_wait: got %0d bad cycles (busy/somi/frame_err), expected 0", bad);
    else n_pass++;
    core_done = 1'b1;
    core_data = res;
  endtask

  task automatic collect(output logic [127:0] got, input int n);
    got = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin
        core_done = 1'b0;
        core_data = rand128();
      end
      got[k] = somi;
    end
  endtask

  task automatic score_result(input logic [127:0] got, input string name);
    logic [127:0] exp;
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic end_frame();
    @(negedge clk);
    cs_n = 1'b1;
    n_checks++;
    if ({busy, frame_err, somi} !== 3'b000)
      $display("FAIL frame_end: got busy/err/somi=%b expected 000", {busy, frame_err, somi});
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({somi_a, start_a, busy_a, err_a, mode_a} !== 5'b0)
      $display("FAIL reset_ctrl4: got %b expected 00000", {somi_a, start_a, busy_a, err_a, mode_a});
    else n_pass++;
    n_checks++;
    if ({somi_b, start_b, busy_b, err_b, mode_b} !== 5'b0)
      $display("FAIL reset_ctrl8: got %b expected 00000", {somi_b, start_b, busy_b, err_b, mode_b});
    else n_pass++;
    n_checks++;
    if ({msg_a, key_a} !== 256'b0) $display("FAIL reset_data4: got %h expected 0", {msg_a, key_a});
    else n_pass++;
    n_checks++;
    if ({msg_b, key_b} !== 384'b0) $display("FAIL reset_data8: got %h expected 0", {msg_b, key_b});
    else n_pass++;
    n_checks++;
    if (dbg_a !== IDLE || dbg_b !== IDLE) $display("FAIL reset_state: got %0d/%0d expected 0/0", dbg_a, dbg_b);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_fips();
    logic [127:0] got;
    sel8 = 1'b0;
    exp_q.push_back(FIPS_CT);
    load_frame(FIPS_PT, {128'b0, FIPS_KEY}, 1'b0, 1'b0);
    check_start(FIPS_PT, {128'b0, FIPS_KEY}, 1'b0);
    serve_core(11, FIPS_CT);
    collect(got, 128);
    score_result(got, "fips_somi");
    end_frame();
  endtask

  task automatic test_abort();
    logic [127:0] msg;
    sel8 = 1'b0;
    msg = rand128();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cs_n = 1'b0;
      simo = msg[i];
      mode = 1'b0;
    end
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({frame_err, busy, start_o} !== 3'b100)
      $display("FAIL abort_pulse: got err/busy/start=%b expected 100", {frame_err, busy, start_o});
    else n_pass++;
    n_checks++;
    if (dbg_a !== IDLE) $display("FAIL abort_state: got %0d expected %0d", dbg_a, IDLE);
    else n_pass++;
    core_done = 1'b1;
    core_data = rand128();
    @(negedge clk);
    core_done = 1'b0;
    n_checks++;
    if ({frame_err, busy, somi} !== 3'b000)
      $display("FAIL abort_after: got err/busy/somi=%b expected 000", {frame_err, busy, somi});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, somi} !== 2'b00) $display("FAIL late_done: got busy/somi=%b expected 00", {busy, somi});
    else n_pass++;
  endtask

  task automatic test_long_wait();
    logic [127:0] msg, res, got;
    logic [255:0] key;
    sel8 = 1'b0;
    msg = rand128();
    key = {128'b0, rand128()};
    res = rand128();
    exp_q.push_back(res);
    load_frame(msg, key, 1'b0, 1'b0);
    check_start(msg, key, 1'b0);
    serve_core(1000, res);
    collect(got, 128);
    score_result(got, "long_wait_somi");
    end_frame();
  endtask

  task automatic test_back_to_back();
    logic [127:0] msg, res, got;
    logic [255:0] key;
    sel8 = 1'b0;
    for (int f = 0; f < 2; f++) begin
      msg = rand128();
      key = {128'b0, rand128()};
      res = rand128();
      exp_q.push_back(res);
      load_frame(msg, key, 1'b0, f == 0);
      check_start(msg, key, 1'b0);
      serve_core($urandom_range(1, 6), res);
      collect(got, 128);
      score_result(got, "b2b_somi");
    end
    end_frame();
  endtask

  task automatic test_nk8();
    logic [127:0] msg, res, got;
    logic [255:0] key;
    sel8 = 1'b1;
    msg = rand128();
    key = {rand128(), rand128()};
    res = rand128();
    exp_q.push_back(res);
    load_frame(msg, key, 1'b0, 1'b0);
    check_start(msg, key, 1'b0);
    serve_core(2, res);
    collect(got, 128);
    score_result(got, "nk8_somi");
    end_frame();
    msg = rand128();
    key = {rand128(), rand128()};
`ifdef AES_SPI_CTRL_DECRYPT_EN
    res = rand128();
    exp_q.push_back(res);
    load_frame(msg, key, 1'b1, 1'b0);
    check_start(msg, key, 1'b1);
    serve_core(3, res);
    collect(got, 128);
    score_result(got, "nk8_decrypt_somi");
    end_frame();
`else
    load_frame(msg, key, 1'b1, 1'b0);
    @(negedge clk);
    cs_n = 1'b1;
    n_checks++;
    if ({start_o, frame_err, busy, mode_o} !== 4'b0100)
      $display("FAIL decrypt_reject: got start/err/busy/mode=%b expected 0100",
               {start_o, frame_err, busy, mode_o});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({start_o, frame_err, busy} !== 3'b000)
      $display("FAIL decrypt_reject_after: got start/err/busy=%b expected 000", {start_o, frame_err, busy});
    else n_pass++;
`endif
    sel8 = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic [127:0] msg, res, got;
    logic [255:0] key;
    sel8 = 1'b0;
    msg = rand128();
    key = {128'b0, rand128()};
    res = rand128();
    load_frame(msg, key, 1'b0, 1'b0);
    check_start(msg, key, 1'b0);
    serve_core(3, res);
    collect(got, 65);
    rst_n = 1'b0;
    n_checks++;
    if (got[64:0] !== res[64:0]) $display("FAIL partial_somi: got %h expected %h", got[64:0], res[64:0]);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({somi, start_o, busy, frame_err, mode_o} !== 5'b0)
      $display("FAIL midreset_ctrl: got %b expected 00000", {somi, start_o, busy, frame_err, mode_o});
    else n_pass++;
    n_checks++;
    if ({msg_a, key_a} !== 256'b0) $display("FAIL midreset_data: got %h expected 0", {msg_a, key_a});
    else n_pass++;
    n_checks++;
    if (dbg_a !== IDLE) $display("FAIL midreset_state: got %0d expected %0d", dbg_a, IDLE);
    else n_pass++;
    rst_n = 1'b1;
    cs_n  = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, somi} !== 2'b00) $display("FAIL midreset_after: got busy/somi=%b expected 00", {busy, somi});
    else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b0;
    sel8      = 1'b0;
    cs_n      = 1'b1;
    simo      = 1'b0;
    mode      = 1'b0;
    core_done = 1'b0;
    core_data = '0;
    test_reset();
    test_fips();
    test_abort();
    test_long_wait();
    test_back_to_back();
    test_nk8();
    test_reset_mid_shift();
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
